shared_mem_arbiter: RTL

//  Two-requester round-robin arbiter and sequencer for one single-port byte scratch RAM
//  (DATA_W x 2**ADDR_W) used by the RSA datapath. Port 0 is the host/vector loader; port 1 is the modexp core.

---
 rtl/shared_mem_pkg.sv | 16 +
 rtl/shared_mem_arbiter_sp_ram.sv | 29 ++
 rtl/shared_mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/shared_mem_pkg.sv
// Shared types and constants for the RSA scratch RAM arbiter.
// Optional RAM zero-fill after reset is enabled by MEM_CLEAR_EN.
package shared_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/shared_mem_arbiter_sp_ram.sv
// Single-port RAM: synchronous write, registered read.
// Contents are never reset.
module sp_ram
  import shared_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Two-port round-robin arbiter for the RSA scratch RAM.
// Define MEM_CLEAR_EN to zero-fill the RAM after reset.
module shared_mem_arbiter
  import shared_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              init_done
);

  logic              r_rr_last;
  logic              r_rv0;
  logic              r_rv1;
  logic [DATA_W-1:0] r_hold0;
  logic [DATA_W-1:0] r_hold1;

  logic              w_run;
  logic              w_clr;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_g0;
  logic              w_g1;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

`ifdef MEM_CLEAR_EN
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == '1) r_state <= RUN;
    end
  end

  assign w_run      = rst_n & (r_state == RUN);
  assign w_clr      = rst_n & (r_state == CLEAR);
  assign w_clr_addr = r_clr_addr;
  assign init_done  = (r_state == RUN);
`else
  assign w_run      = rst_n;
  assign w_clr      = 1'b0;
  assign w_clr_addr = '0;
  assign init_done  = 1'b1;
`endif

  // On a tie the port that was not granted last wins.
  assign w_g0 = w_run & r0_req & (~r1_req | (r_rr_last == PORT1));
  assign w_g1 = w_run & r1_req & (~r0_req | (r_rr_last == PORT0));

  assign r0_gnt = w_g0;
  assign r1_gnt = w_g1;

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    unique case (1'b1)
      w_clr: begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = w_clr_addr;
      end
      w_g0: begin
        w_ram_en    = 1'b1;
        w_ram_we    = r0_we;
        w_ram_addr  = r0_addr;
        w_ram_wdata = r0_wdata;
      end
      w_g1: begin
        w_ram_en    = 1'b1;
        w_ram_we    = r1_we;
        w_ram_addr  = r1_addr;
        w_ram_wdata = r1_wdata;
      end
      default: ;
    endcase
  end

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= PORT1;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_hold0   <= '0;
      r_hold1   <= '0;
    end else begin
      r_rv0 <= w_g0 & ~r0_we;
      r_rv1 <= w_g1 & ~r1_we;
      if (w_g0)      r_rr_last <= PORT0;
      else if (w_g1) r_rr_last <= PORT1;
      if (r_rv0) r_hold0 <= w_ram_rdata;
      if (r_rv1) r_hold1 <= w_ram_rdata;
    end
  end

  // The shared RAM output register is steered to the owning port;
  // each port keeps its last returned word between reads.
  assign r0_rvalid = r_rv0;
  assign r1_rvalid = r_rv1;
  assign r0_rdata  = r_rv0 ? w_ram_rdata : r_hold0;
  assign r1_rdata  = r_rv1 ? w_ram_rdata : r_hold1;

endmodule
